// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU (default priority) and a DMA master,
// with a starvation bound and a bounded DMA burst lock. Optional grant statistics via MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] cpu_grant_cnt,
  output logic [15:0] dma_grant_cnt,
  output logic        starve_evt
`endif
);
  typedef enum logic [1:0] {ARB, BURST, CPUPRI} state_t;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  state_t     r_state;
  logic [3:0] r_starve, r_burst;
  logic       r_cpu_rvalid, r_dma_rvalid;
  logic       w_hold, w_cpu_gnt, w_dma_gnt;
  logic [3:0] w_burst_nx;
  // Grants are forced low while reset is held so nothing reaches memory mid-reset.
  always_comb begin
    w_hold     = r_state == BURST && dma_req && dma_lock;
    w_dma_gnt  = !rst ? 1'b0 : w_hold ? 1'b1 : r_state == CPUPRI ? dma_req && !cpu_req :
                 dma_req && (!cpu_req || r_starve == MW);
    w_cpu_gnt  = rst && cpu_req && !w_dma_gnt;
    w_burst_nx = r_burst + 4'd1;
  end
  assign cpu_gnt    = w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  assign rdata      = mem_rdata;
  assign mem_addr   = w_cpu_gnt ? cpu_addr : w_dma_gnt ? dma_addr : 16'h0;
  assign mem_we     = w_cpu_gnt ? cpu_we : w_dma_gnt && dma_we;
  assign mem_wdata  = w_cpu_gnt ? cpu_wdata : w_dma_gnt ? dma_wdata : 16'h0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB;
      r_starve     <= 4'd0;
      r_burst      <= 4'd0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt && !cpu_we;
      r_dma_rvalid <= w_dma_gnt && !dma_we;
      r_starve     <= (dma_req && !w_dma_gnt) ? (r_starve == MW ? MW : r_starve + 4'd1) : 4'd0;
      if (r_state == ARB && w_dma_gnt && dma_lock) begin
        r_state <= (MB == 4'd1) ? CPUPRI : BURST;
        r_burst <= 4'd1;
      end else if (w_hold) begin
        r_state <= (w_burst_nx == MB) ? CPUPRI : BURST;
        r_burst <= w_burst_nx;
      end else begin
        r_state <= ARB;
        r_burst <= 4'd0;
      end
    end
  end
`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_cpu_cnt, r_dma_cnt;
  logic        r_starve_evt, w_forced;
  // A DMA win in arbitration while the CPU is also asking can only come from the starvation bound.
  assign w_forced      = r_state != CPUPRI && !w_hold && w_dma_gnt && cpu_req;
  assign cpu_grant_cnt = r_cpu_cnt;
  assign dma_grant_cnt = r_dma_cnt;
  assign starve_evt    = r_starve_evt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_cnt    <= 16'h0;
      r_dma_cnt    <= 16'h0;
      r_starve_evt <= 1'b0;
    end else begin
      r_cpu_cnt    <= r_cpu_cnt + 16'(w_cpu_gnt);
      r_dma_cnt    <= r_dma_cnt + 16'(w_dma_gnt);
      r_starve_evt <= w_forced;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized check of mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;
  localparam int MW = 4;
  localparam int MB = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, dma_lock = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_grant_cnt, dma_grant_cnt;
  logic        starve_evt;
`endif
  always #5 clk = ~clk;
  mem_port_arbiter #(.MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .cpu_grant_cnt(cpu_grant_cnt), .dma_grant_cnt(dma_grant_cnt), .starve_evt(starve_evt)
`endif
  );
  int n_chk = 0, n_fail = 0;
  // Model: consecutive starved cycles, length of the current locked run, and whether the CPU owns the next cycle.
  int waited = 0, burst_len = 0;
  bit locked = 0, cpu_turn = 0, pend_cpu = 0, pend_dma = 0, pend_evt = 0;
  logic [15:0] pend_data = 0, cnt_c = 0, cnt_d = 0;
  logic [15:0] mem [256];
  bit e_cpu, e_dma, e_we, hold;
  logic [15:0] e_addr, e_wdata;
  logic s_cpu_gnt, s_dma_gnt, s_cpu_rv, s_dma_rv, s_we, s_evt;
  logic [15:0] s_addr, s_wdata, s_rdata, s_ccnt, s_dcnt;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic cr, cw, input logic [15:0] ca, cd,
                      input logic dr, dw, input logic [15:0] da, dd, input logic dl, r);
    bit forced;
    @(negedge clk);
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
    if (!r) begin
      waited = 0; burst_len = 0; locked = 0; cpu_turn = 0;
      pend_cpu = 0; pend_dma = 0; pend_evt = 0; cnt_c = 0; cnt_d = 0;
    end
    mem_rdata = (pend_cpu || pend_dma) ? pend_data : 16'($urandom);
    hold = locked && dr && dl;
    if (!r) begin e_cpu = 0; e_dma = 0; end
    else if (hold) begin e_cpu = 0; e_dma = 1; end
    else if (cpu_turn) begin e_cpu = cr; e_dma = dr && !cr; end
    else begin e_dma = dr && (!cr || waited >= MW); e_cpu = cr && !e_dma; end
    e_we    = e_cpu ? cw : (e_dma && dw);
    e_addr  = e_cpu ? ca : e_dma ? da : 16'h0;
    e_wdata = e_cpu ? cd : e_dma ? dd : 16'h0;
    #1;
    s_cpu_gnt = cpu_gnt; s_dma_gnt = dma_gnt; s_cpu_rv = cpu_rvalid; s_dma_rv = dma_rvalid;
    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_rdata = rdata;
    chk("cpu_gnt", cpu_gnt, e_cpu);
    chk("dma_gnt", dma_gnt, e_dma);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rvalid", cpu_rvalid, pend_cpu);
    chk("dma_rvalid", dma_rvalid, pend_dma);
    if (pend_cpu || pend_dma) chk("rdata", rdata, pend_data);
`ifdef MEM_ARB_STATS_EN
    s_ccnt = cpu_grant_cnt; s_dcnt = dma_grant_cnt; s_evt = starve_evt;
    chk("cpu_grant_cnt", cpu_grant_cnt, cnt_c);
    chk("dma_grant_cnt", dma_grant_cnt, cnt_d);
    chk("starve_evt", starve_evt, pend_evt);
`endif
    @(posedge clk);
    if (r) begin
      forced = !hold && !cpu_turn && e_dma && cr;
      waited = (dr && !e_dma) ? (waited < MW ? waited + 1 : MW) : 0;
      if (hold) begin
        burst_len++;
        locked = burst_len < MB;
        cpu_turn = burst_len == MB;
      end else if (!cpu_turn && e_dma && dl) begin
        burst_len = 1;
        locked = MB > 1;
        cpu_turn = MB == 1;
      end else begin
        burst_len = 0; locked = 0; cpu_turn = 0;
      end
      pend_cpu = e_cpu && !cw;
      pend_dma = e_dma && !dw;
      pend_data = mem[e_addr[7:0]];
      if (e_we) mem[e_addr[7:0]] = e_wdata;
      cnt_c = cnt_c + 16'(e_cpu);
      cnt_d = cnt_d + 16'(e_dma);
      pend_evt = forced;
    end
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  initial begin
    logic [15:0] pat_c, pat_d;
    int ev;
    logic [15:0] c0, d0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'h1234;
    step(1, 0, 16'h0010, 0, 1, 0, 16'h0300, 0, 1, 0);
    step(1, 0, 16'h0010, 0, 1, 0, 16'h0300, 0, 1, 0);
    chk("rst_cpu_gnt", s_cpu_gnt, 0);
    chk("rst_dma_gnt", s_dma_gnt, 0);
    chk("rst_mem_we", s_we, 0);
    chk("rst_rvalid", {s_cpu_rv, s_dma_rv}, 0);
    step(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0, 1);
    chk("rd_cpu_gnt", s_cpu_gnt, 1);
    chk("rd_addr", s_addr, 16'h0010);
    idle();
    chk("rd_cpu_rvalid", s_cpu_rv, 1);
    chk("rd_rdata", s_rdata, 16'h1234);
    pat_c = 0; pat_d = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 16'($urandom), 0, 1, 1, 16'h0300, 16'($urandom), 0, 1);
      pat_c[i] = s_cpu_gnt; pat_d[i] = s_dma_gnt;
    end
    chk("ratio_dma", pat_d, 16'h0210);
    chk("ratio_cpu", pat_c, 16'h01EF);
    idle();
    pat_c = 0; pat_d = 0;
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 16'($urandom), 0, 1, 0, 16'($urandom), 0, 1, 1);
      pat_c[i] = s_cpu_gnt; pat_d[i] = s_dma_gnt;
    end
    chk("burst_dma", pat_d, 16'h0FF0);
    chk("burst_cpu", pat_c, 16'h100F);
    idle();
    step(0, 0, 0, 0, 1, 0, 16'h0044, 0, 1, 1);
    step(1, 0, 16'h0021, 0, 1, 0, 16'h0045, 0, 1, 1);
    step(1, 0, 16'h0021, 0, 1, 0, 16'h0046, 0, 1, 1);
    chk("lock3_dma", s_dma_gnt, 1);
    step(1, 0, 16'h0021, 0, 1, 0, 16'h0047, 0, 0, 1);
    chk("lockdrop_cpu", s_cpu_gnt, 1);
    chk("lockdrop_dma", s_dma_gnt, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0048, 0, 0, 1);
    step(1, 0, 16'h0022, 0, 1, 0, 16'h0049, 0, 1, 1);
    chk("back_in_arb", s_cpu_gnt, 1);
    idle();
    step(0, 0, 0, 0, 1, 1, 16'h0200, 16'hBEEF, 0, 1);
    chk("wr_dma_gnt", s_dma_gnt, 1);
    chk("wr_bus", {s_we, s_addr, s_wdata}, {1'b1, 16'h0200, 16'hBEEF});
    step(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0, 1);
    chk("wr_no_dma_rv", s_dma_rv, 0);
    chk("rd_after_wr_we", s_we, 0);
    idle();
    chk("rd_after_wr_rv", {s_cpu_rv, s_dma_rv}, 2'b10);
    chk("rd_after_wr_data", s_rdata, 16'h1234);
`ifdef MEM_ARB_STATS_EN
    idle();
    ev = 0;
    for (int i = 0; i <= 50; i++) begin
      step(1, 0, 16'($urandom), 0, 1, 1, 16'h0300, 0, 0, 1);
      if (i == 0) begin c0 = s_ccnt; d0 = s_dcnt; end
      else ev += int'(s_evt);
    end
    chk("stats_cpu", 16'(s_ccnt - c0), 16'd40);
    chk("stats_dma", 16'(s_dcnt - d0), 16'd10);
    chk("stats_evt", ev, 10);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 16'($urandom), 16'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, 16'($urandom), 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
